// File: rtl/priority_encoder_16to4.sv
// priority_encoder_16to4
//   Accepts a 16-bit request vector and emits the index of every set bit,
//   one beat per cycle, under a valid/ready handshake on both sides.
//   PRIORITY_LSB=1 emits the lowest set bit first; PRIORITY_LSB=0 emits the
//   highest set bit first.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_vec is presented
//   in_ready  : block is idle and can take a vector
//   in_vec    : request vector, any number of bits set
//   out_valid : out_idx is valid
//   out_ready : consumer takes out_idx
//   out_idx   : index of the current highest-priority pending bit
//   out_last  : current beat is the final one for this vector
//   pend_cnt  : number of bits still pending (0..16)
//   zero_vec  : one-cycle pulse after an all-zero vector is accepted

// Per-lane slice: encodes and counts one LANE_W-bit group of the pending vector.
module pe_lane #(
  parameter int LANE_W       = 4,
  parameter bit PRIORITY_LSB = 1'b1,
  parameter int IW           = $clog2(LANE_W),
  parameter int CW           = $clog2(LANE_W + 1)
) (
  input  logic [LANE_W-1:0] lane_bits,
  output logic              lane_any,
  output logic [IW-1:0]     lane_idx,
  output logic [CW-1:0]     lane_cnt
);

  always_comb begin
    lane_any = |lane_bits;
    lane_idx = '0;
    lane_cnt = '0;
    for (int i = 0; i < LANE_W; i++)
      lane_cnt = lane_cnt + CW'(lane_bits[i]);
    // Scan toward the winning end so the last hit is the priority bit.
    if (PRIORITY_LSB) begin
      for (int i = LANE_W - 1; i >= 0; i--)
        if (lane_bits[i]) lane_idx = IW'(i);
    end else begin
      for (int i = 0; i < LANE_W; i++)
        if (lane_bits[i]) lane_idx = IW'(i);
    end
  end

endmodule

module priority_encoder_16to4 #(
  parameter int PRIORITY_LSB = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_vec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_idx,
  output logic        out_last,
  output logic [4:0]  pend_cnt,
  output logic        zero_vec
);

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]  state;
  logic [15:0] pending;

  logic [NUM_LANES-1:0][LANE_W-1:0] lane_bits;
  logic [NUM_LANES-1:0]             lane_any;
  logic [NUM_LANES-1:0][1:0]        lane_idx;
  logic [NUM_LANES-1:0][2:0]        lane_cnt;

  assign lane_bits = pending;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      pe_lane #(
        .LANE_W       (LANE_W),
        .PRIORITY_LSB (PRIORITY_LSB != 0)
      ) u_lane (
        .lane_bits (lane_bits[g]),
        .lane_any  (lane_any[g]),
        .lane_idx  (lane_idx[g]),
        .lane_cnt  (lane_cnt[g])
      );
    end
  endgenerate

  // Second level: pick the winning lane and sum the lane counts. With
  // pending==0 nothing hits, so out_idx rests at 0 (reset requirement).
  always_comb begin
    out_idx  = '0;
    pend_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++)
      pend_cnt = pend_cnt + 5'(lane_cnt[i]);
    if (PRIORITY_LSB != 0) begin
      for (int i = NUM_LANES - 1; i >= 0; i--)
        if (lane_any[i]) out_idx = {2'(i), lane_idx[i]};
    end else begin
      for (int i = 0; i < NUM_LANES; i++)
        if (lane_any[i]) out_idx = {2'(i), lane_idx[i]};
    end
  end

  assign out_last  = (pend_cnt == 5'd1);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);

  // Reset is async so that pending, and everything derived from it,
  // clears the moment rst_n falls, even in the middle of a vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= '0;
      zero_vec <= 1'b0;
    end else begin
      zero_vec <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_vec == '0) begin
              zero_vec <= 1'b1;
            end else begin
              pending <= in_vec;
              state   <= EMIT;
            end
          end
        end
        EMIT: begin
          // in_valid is ignored here; only the output handshake moves state.
          if (out_ready) begin
            pending[out_idx] <= 1'b0;
            if (out_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/priority_encoder_16to4.md
PRIORITY_ENCODER_16TO4 -- requirements
Module: priority_encoder_16to4

Interface
REQ-001 The block SHALL have parameter PRIORITY_LSB, default 1, which selects the emit order: 1 means lowest set bit first, 0 means highest set bit first.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_vec is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a vector.
REQ-006 The block SHALL have port in_vec, input, 16 bits: request vector, any number of bits set.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_idx is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_idx.
REQ-009 The block SHALL have port out_idx, output, 4 bits: binary index of the current highest-priority pending bit.
REQ-010 The block SHALL have port out_last, output, 1 bit: the current beat is the final beat for this vector.
REQ-011 The block SHALL have port pend_cnt, output, 5 bits: number of bits still pending, range 0..16.
REQ-012 The block SHALL have port zero_vec, output, 1 bit: one-cycle pulse when an accepted vector is all zeros.

Function
REQ-013 The block SHALL implement a two-state FSM with states IDLE and EMIT and a 16-bit pending register.
REQ-014 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==EMIT).
REQ-015 The block SHALL accept a vector only on a clock edge where in_valid && in_ready; in_valid in EMIT SHALL be ignored with no effect on pending.
REQ-016 On accepting a nonzero in_vec, the block SHALL load pending<=in_vec and enter EMIT, so the first out_valid appears one cycle after acceptance.
REQ-017 On accepting in_vec==0, the block SHALL remain in IDLE, leave pending at 0, and assert zero_vec for exactly one cycle (the cycle after acceptance).
REQ-018 out_idx SHALL be derived combinationally from pending: the lowest set index when PRIORITY_LSB=1, the highest set index when PRIORITY_LSB=0.
REQ-019 out_last SHALL be 1 when pend_cnt==1 and 0 otherwise; pend_cnt SHALL be the population count of pending.
REQ-020 On out_valid && out_ready, the block SHALL clear the bit at out_idx in pending; if out_last=1, it SHALL return to IDLE so that in_ready=1 in the next cycle.
REQ-021 Throughput SHALL be one beat per cycle while out_ready stays high; an N-bit vector SHALL complete in N consecutive beats.
REQ-022 While out_valid=1 and out_ready=0, out_idx, out_last and pend_cnt SHALL hold stable.
REQ-023 There SHALL be no overlap between vectors: a new vector is accepted no earlier than the cycle after the last beat.

Reset
REQ-024 While rst_n=0, state SHALL be IDLE and pending SHALL be 0, asynchronously to clk.
REQ-025 While rst_n=0, out_valid=0, out_idx=0, out_last=0, pend_cnt=0, zero_vec=0 and in_ready=1.
REQ-026 Asserting rst_n mid-EMIT SHALL discard all pending bits immediately, without waiting for a clock edge.
REQ-027 After rst_n deasserts, the block SHALL process the first accepted vector normally.

Verification
REQ-028 Reset, then in_vec=16'h8421 with out_ready=1 held -> out_idx 0,5,10,15 on 4 consecutive cycles; pend_cnt 4,3,2,1; out_last=1 only on idx 15; in_ready=1 on the following cycle.
REQ-029 Same stimulus with PRIORITY_LSB=0 -> out_idx 15,10,5,0; out_last=1 only on idx 0.
REQ-030 in_vec=16'hFFFF with out_ready toggling 1,0,1,0 -> 16 beats, idx 0..15 in order; idx, last and cnt held during out_ready=0 cycles; no beat lost or repeated.
REQ-031 in_vec=16'h0000 accepted -> zero_vec=1 for one cycle, out_valid stays 0, in_ready stays 1.
REQ-032 in_vec=16'h00FF; pulse rst_n low after 2 beats -> out_valid=0 and pend_cnt=0 immediately; then in_vec=16'h0100 -> single beat, idx 8, out_last=1.
REQ-033 in_valid=1 with in_vec=16'h0003 held during EMIT of 16'h0010 -> only idx 4 is emitted; 16'h0003 is then accepted only after in_ready returns to 1.
